// File: rtl/jardim_pkg.sv
// jardim_pkg: shared state enum, 7-segment constants and animation stepping for jardim_multizona.
package jardim_pkg;

    typedef enum logic [1:0] {IDLE, WATER, GAP} state_t;

    localparam logic [6:0] SEG_IDLE = 7'b0111111;
    localparam logic [6:0] SEG_A    = 7'b1111110;
    localparam logic [6:0] SEG_B    = 7'b1111101;
    localparam logic [6:0] SEG_C    = 7'b1111011;
    localparam logic [6:0] SEG_D    = 7'b1110111;
    localparam logic [6:0] SEG_E    = 7'b1101111;
    localparam logic [6:0] SEG_F    = 7'b1011111;

    // Active-low single segment walks a..f by shifting the zero up one bit; f wraps to a.
    function automatic logic [6:0] seg_next(input logic [6:0] s);
        return s == SEG_F ? SEG_A : {1'b1, s[4:0], 1'b1};
    endfunction

endpackage

// File: rtl/jardim_tick_gen.sv
// jardim_tick_gen: prescaler emitting a one-cycle tick every DIV enabled cycles; clear restarts the count.
module jardim_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int W = DIV > 1 ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i && cnt_q == W'(DIV - 1);
    assign cnt_d  = (clear_i || !enable_i || tick_o) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_i)
        cnt_q <= rst_i ? '0 : cnt_d;

endmodule

// File: rtl/jardim_multizona.sv
// jardim_multizona: sequential multi-zone irrigation controller with status LEDs and sprinkler animation.
// Optional rain input enabled by defining JARDIM_RAIN_SENSOR_EN.
module jardim_multizona
    import jardim_pkg::*;
#(
    parameter int N_ZONES        = 4,
    parameter int CYCLES_PER_SEC = 50000000,
    parameter int DAWN_SECS      = 3,
    parameter int DUSK_SECS      = 6,
    parameter int GAP_SECS       = 1,
    parameter int ANIM_CYCLES    = 5000000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               amanhecer,
    input  logic               anoitecer,
    input  logic               controle,
`ifdef JARDIM_RAIN_SENSOR_EN
    input  logic               chuva,
`endif
    output logic [N_ZONES-1:0] valve,
    output logic [2:0]         zone,
    output logic               LEDG,
    output logic               LEDR,
    output logic [6:0]         HEX0
);

    localparam logic [2:0] LAST = 3'(N_ZONES - 1);

    state_t             state_q, state_d;
    logic [2:0]         zone_q, zone_d;
    logic [3:0]         dur_q, dur_d, sec_q, target;
    logic [2:0]         hist_q, req, edg;
    logic               armed_q;
    logic [N_ZONES-1:0] valve_q;
    logic               ledg_q, ledr_q;
    logic [6:0]         hex_q;
    logic               sec_tick, anim_tick, done, change, start, stop, allow;

    // armed_q keeps the first post-reset cycle from seeing a held request as an edge.
    assign req    = {controle, anoitecer, amanhecer};
    assign edg    = req & ~hist_q & {3{armed_q}};
    assign target = state_q == GAP ? 4'(GAP_SECS) : dur_q;
    assign done   = sec_tick && sec_q == target - 4'd1;
    assign change = state_d != state_q || zone_d != zone_q;
    assign start  = state_q == IDLE && state_d == WATER;

`ifdef JARDIM_RAIN_SENSOR_EN
    logic rain_q, stop_q;
    assign allow = !chuva;
    assign stop  = stop_q || (chuva && !rain_q && armed_q && state_q != IDLE);
    always_ff @(posedge CLOCK_50) begin
        rain_q <= !reset && chuva;
        stop_q <= !reset && state_d != IDLE && stop;
    end
`else
    assign allow = 1'b1;
    assign stop  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        zone_d  = zone_q;
        dur_d   = dur_q;
        if (state_q == IDLE) begin
            if ((edg[0] && allow) || (edg[1] && allow) || edg[2]) begin
                state_d = WATER;
                zone_d  = '0;
                dur_d   = (edg[0] && allow) ? 4'(DAWN_SECS) : 4'(DUSK_SECS);
            end
        end else if (edg[2] || (state_q == GAP && stop)) begin
            state_d = IDLE;
            zone_d  = '0;
        end else if (done) begin
            if (state_q == GAP || (GAP_SECS == 0 && zone_q != LAST && !stop)) begin
                state_d = WATER;
                zone_d  = zone_q + 3'd1;
            end else if (zone_q == LAST || stop) begin
                state_d = IDLE;
                zone_d  = '0;
            end else begin
                state_d = GAP;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            zone_q  <= '0;
            dur_q   <= '0;
            sec_q   <= '0;
            hist_q  <= '0;
            armed_q <= 1'b0;
            valve_q <= '0;
            ledg_q  <= 1'b0;
            ledr_q  <= 1'b1;
            hex_q   <= SEG_IDLE;
        end else begin
            state_q <= state_d;
            zone_q  <= zone_d;
            dur_q   <= dur_d;
            sec_q   <= change ? 4'd0 : sec_q + {3'd0, sec_tick};
            hist_q  <= req;
            armed_q <= 1'b1;
            valve_q <= state_d == WATER ? N_ZONES'(1) << zone_d : '0;
            ledg_q  <= state_d != IDLE;
            ledr_q  <= state_d == IDLE;
            hex_q   <= state_d == IDLE ? SEG_IDLE : start ? SEG_A : anim_tick ? seg_next(hex_q) : hex_q;
        end
    end

    jardim_tick_gen #(.DIV(CYCLES_PER_SEC)) u_sec (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .clear_i (change),
        .enable_i(state_q != IDLE),
        .tick_o  (sec_tick)
    );

    jardim_tick_gen #(.DIV(ANIM_CYCLES)) u_anim (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .clear_i (start),
        .enable_i(state_q != IDLE),
        .tick_o  (anim_tick)
    );

    assign valve = valve_q;
    assign zone  = zone_q;
    assign LEDG  = ledg_q;
    assign LEDR  = ledr_q;
    assign HEX0  = hex_q;

endmodule

// File: tb/tb_jardim_multizona.sv
// tb_jardim_multizona: checks a GAP_SECS=1 and a GAP_SECS=0 instance against a countdown model plus literal timeline points.
module tb_jardim_multizona;

    localparam int NZ   = 3;
    localparam int CPS  = 10;
    localparam int DAWN = 3;
    localparam int DUSK = 6;
    localparam int ANIM = 2;
    localparam int GAPS [2] = '{1, 0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic amanhecer = 1'b0, anoitecer = 1'b0, controle = 1'b0;
    logic [NZ-1:0] v [2];
    logic [2:0]    z [2];
    logic          lg [2], lr [2];
    logic [6:0]    hx [2];

    int total = 0, bad = 0, rel = 0;
    bit live = 0;

    always #5 clk = ~clk;

    jardim_multizona #(.N_ZONES(NZ), .CYCLES_PER_SEC(CPS), .DAWN_SECS(DAWN), .DUSK_SECS(DUSK),
                       .GAP_SECS(1), .ANIM_CYCLES(ANIM)) dut (
        .CLOCK_50(clk), .reset(reset), .amanhecer(amanhecer), .anoitecer(anoitecer), .controle(controle),
        .valve(v[0]), .zone(z[0]), .LEDG(lg[0]), .LEDR(lr[0]), .HEX0(hx[0]));

    jardim_multizona #(.N_ZONES(NZ), .CYCLES_PER_SEC(CPS), .DAWN_SECS(DAWN), .DUSK_SECS(DUSK),
                       .GAP_SECS(0), .ANIM_CYCLES(ANIM)) dut0 (
        .CLOCK_50(clk), .reset(reset), .amanhecer(amanhecer), .anoitecer(anoitecer), .controle(controle),
        .valve(v[1]), .zone(z[1]), .LEDG(lg[1]), .LEDR(lr[1]), .HEX0(hx[1]));

    // Model: mode 0 idle / 1 water / 2 gap, cycles left in the phase, cycles since the run started.
    int mode [2], zn [2], left [2], dur [2], an [2];
    logic [2:0] prev = '0;
    bit armed = 0;
    logic [6:0] segs [6] = '{7'b1111110, 7'b1111101, 7'b1111011, 7'b1110111, 7'b1101111, 7'b1011111};

    always @(posedge clk) begin
        logic [2:0] rq, e;
        rq = {controle, anoitecer, amanhecer};
        e = rq & ~prev & {3{armed}};
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mode[i] = 0; zn[i] = 0;
            end else if (mode[i] == 0) begin
                if (e != 3'b000) begin
                    mode[i] = 1; zn[i] = 0; an[i] = 0;
                    dur[i] = (e[0] ? DAWN : DUSK) * CPS;
                    left[i] = dur[i];
                end
            end else if (e[2]) begin
                mode[i] = 0; zn[i] = 0;
            end else begin
                an[i]++;
                left[i]--;
                if (left[i] == 0) begin
                    if (mode[i] == 2) begin
                        mode[i] = 1; zn[i]++; left[i] = dur[i];
                    end else if (zn[i] == NZ - 1) begin
                        mode[i] = 0; zn[i] = 0;
                    end else if (GAPS[i] > 0) begin
                        mode[i] = 2; left[i] = GAPS[i] * CPS;
                    end else begin
                        zn[i]++; left[i] = dur[i];
                    end
                end
            end
        end
        prev = reset ? 3'b000 : rq;
        armed = !reset;
        if (reset) live = 1;
    end

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h time=%0t", nm, i, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 2; i++) begin
                chk("valve", i, 32'(v[i]), mode[i] == 1 ? 32'(1 << zn[i]) : 32'd0);
                chk("zone", i, 32'(z[i]), 32'(zn[i]));
                chk("ledg", i, 32'(lg[i]), 32'(mode[i] != 0));
                chk("ledr", i, 32'(lr[i]), 32'(mode[i] == 0));
                chk("hex", i, 32'(hx[i]), mode[i] == 0 ? 32'h3f : 32'(segs[(an[i] / ANIM) % 6]));
            end
        end
    end

    task automatic go(input int k);
        while (rel < k) begin
            @(negedge clk);
            rel++;
        end
    endtask

    task automatic pulse(input logic [2:0] m);
        {controle, anoitecer, amanhecer} = m;
        rel = 0;
        go(1);
        {controle, anoitecer, amanhecer} = 3'b000;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valve", 0, 32'(v[0]), 32'd0);
        chk("rst_zone", 0, 32'(z[0]), 32'd0);
        chk("rst_ledr", 0, 32'(lr[0]), 32'd1);
        chk("rst_ledg", 0, 32'(lg[0]), 32'd0);
        chk("rst_hex", 0, 32'(hx[0]), 32'h3f);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // dawn run
        pulse(3'b001);
        chk("dawn_t1", 0, 32'(v[0]), 32'b001);
        go(30);  chk("dawn_t30", 0, 32'(v[0]), 32'b001);
        go(31);  chk("dawn_gap", 0, 32'(v[0]), 32'b000);
                 chk("dawn0_z1", 1, 32'(v[1]), 32'b010);
        go(41);  chk("dawn_z1", 0, 32'(v[0]), 32'b010);
                 chk("dawn_zone1", 0, 32'(z[0]), 32'd1);
        go(91);  chk("dawn0_idle", 1, 32'(lr[1]), 32'd1);
        go(110); chk("dawn_z2", 0, 32'(v[0]), 32'b100);
        go(111); chk("dawn_idle", 0, 32'(lr[0]), 32'd1);
        go(115);

        // dusk run; instance 1 has no gap
        pulse(3'b010);
        go(60);  chk("dusk0_t60", 1, 32'(v[1]), 32'b001);
        go(61);  chk("dusk0_t61", 1, 32'(v[1]), 32'b010);
        go(121); chk("dusk0_t121", 1, 32'(v[1]), 32'b100);
        go(180); chk("dusk0_t180", 1, 32'(v[1]), 32'b100);
        go(181); chk("dusk0_idle", 1, 32'(lr[1]), 32'd1);
        go(201); chk("dusk_idle", 0, 32'(lr[0]), 32'd1);
        go(205);

        // abort in zone 1, then fresh dawn run
        pulse(3'b100);
        go(80);  chk("abort_pre", 0, 32'(v[0]), 32'b010);
        controle = 1'b1;
        go(81);  chk("abort_valve", 0, 32'(v[0]), 32'd0);
                 chk("abort_ledr", 0, 32'(lr[0]), 32'd1);
        controle = 1'b0;
        go(85);
        pulse(3'b001);
        chk("restart_v", 0, 32'(v[0]), 32'b001);
        chk("restart_z", 0, 32'(z[0]), 32'd0);
        go(115);

        // simultaneous dawn+dusk, dawn then held
        {anoitecer, amanhecer} = 2'b11;
        rel = 0;
        go(1);
        anoitecer = 1'b0;
        go(31);  chk("both_gap", 0, 32'(v[0]), 32'b000);
        go(111); chk("both_idle", 0, 32'(lr[0]), 32'd1);
        go(140); chk("held_idle", 0, 32'(lr[0]), 32'd1);
        amanhecer = 1'b0;
        go(142);

        // animation then abort
        pulse(3'b100);
        chk("anim_1", 0, 32'(hx[0]), 32'b1111110);
        go(2);   chk("anim_2", 0, 32'(hx[0]), 32'b1111110);
        go(3);   chk("anim_3", 0, 32'(hx[0]), 32'b1111101);
        go(11);  chk("anim_11", 0, 32'(hx[0]), 32'b1011111);
        go(13);  chk("anim_13", 0, 32'(hx[0]), 32'b1111110);
        controle = 1'b1;
        go(14);  chk("anim_idle", 0, 32'(hx[0]), 32'b0111111);
        controle = 1'b0;
        go(16);

        // reset mid-zone-1 with controle held through deassertion
        pulse(3'b100);
        go(75);
        controle = 1'b1;
        reset = 1'b1;
        go(76);  chk("mrst_valve", 0, 32'(v[0]), 32'd0);
                 chk("mrst_zone", 0, 32'(z[0]), 32'd0);
        go(77);
        reset = 1'b0;
        go(90);  chk("held_rst_v", 0, 32'(v[0]), 32'd0);
                 chk("held_rst_r", 0, 32'(lr[0]), 32'd1);
        controle = 1'b0;
        go(92);
        pulse(3'b100);
        chk("retoggle_v", 0, 32'(v[0]), 32'b001);
        go(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
